// File: rtl/sorting_pkt_checker_pkg.sv
// Shared types for the sorted-stream packet checker: FSM states and the
// per-packet error vector layout.
package sorting_chk_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam int ERR_ORDER   = 0;
  localparam int ERR_NO_SOP  = 1;
  localparam int ERR_DUP_SOP = 2;
  localparam int ERR_OVERLEN = 3;

  typedef logic [3:0] err_t;

  function automatic err_t err_bit(input int unsigned idx);
    return err_t'(4'd1) << idx;
  endfunction

endpackage

// File: rtl/sorting_pkt_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sorting_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sorting_pkt_checker.sv
// Avalon-ST sink checking framing, length and ordering of sorted packets.
// Optional macro SORTING_PKT_CHECKER_STRICT_EN: require strictly ascending data.
module sorting_pkt_checker
  import sorting_chk_pkg::*;
#(
  parameter int DWIDTH      = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                clk_i,
  input  logic                                arst_n_i,
  input  logic [DWIDTH-1:0]                   snk_data_i,
  input  logic                                snk_startofpacket_i,
  input  logic                                snk_endofpacket_i,
  input  logic                                snk_valid_i,
  output logic                                snk_ready_o,
  input  logic                                ready_en_i,
  input  logic                                clr_i,
  output logic                                pkt_done_o,
  output logic [$clog2(MAX_PKT_LEN+2)-1:0]    pkt_len_o,
  output logic [3:0]                          pkt_err_o,
  output logic [CNT_WIDTH-1:0]                pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]                err_cnt_o
);

  localparam int LW = $clog2(MAX_PKT_LEN + 2);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_PKT_LEN + 1);

  function automatic logic order_bad(input logic [DWIDTH-1:0] cur,
                                     input logic [DWIDTH-1:0] prv);
`ifdef SORTING_PKT_CHECKER_STRICT_EN
    return cur <= prv;
`else
    return cur < prv;
`endif
  endfunction

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  err_t              err_q, err_d;
  logic              nosop_q, nosop_d;
  logic              slot_vld_q, slot_vld_d;
  logic [LW-1:0]     slot_len_q, slot_len_d;
  err_t              slot_err_q, slot_err_d;
  logic              done_q, done_d;
  logic [LW-1:0]     out_len_q, out_len_d;
  err_t              out_err_q, out_err_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              c0_vld;
  logic [LW-1:0]     c0_len;
  err_t              c0_err;
  logic              c1_vld;
  err_t              open_err;
  logic [LW-1:0]     step_len;
  err_t              step_err;

  assign ready_d = ready_en_i;
  assign accept  = snk_valid_i & ready_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    prev_d     = prev_q;
    err_d      = err_q;
    nosop_d    = nosop_q;
    slot_vld_d = slot_vld_q;
    slot_len_d = slot_len_q;
    slot_err_d = slot_err_q;
    done_d     = 1'b0;
    out_len_d  = out_len_q;
    out_err_d  = out_err_q;
    c0_vld     = 1'b0;
    c0_len     = len_q;
    c0_err     = err_q;
    c1_vld     = 1'b0;

    // A stray beat seen while idle is charged to the next packet that opens.
    open_err             = '0;
    open_err[ERR_NO_SOP] = nosop_q;

    step_len = (len_q == LEN_SAT) ? len_q : len_q + LEN_ONE;
    step_err = err_q;
    if (len_q >= LEN_MAX) begin
      step_err[ERR_OVERLEN] = 1'b1;
    end
    if (order_bad(snk_data_i, prev_q)) begin
      step_err[ERR_ORDER] = 1'b1;
    end

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (snk_startofpacket_i) begin
            len_d   = LEN_ONE;
            prev_d  = snk_data_i;
            err_d   = open_err;
            nosop_d = 1'b0;
            if (snk_endofpacket_i) begin
              c0_vld = 1'b1;
              c0_len = LEN_ONE;
              c0_err = open_err;
            end else begin
              state_d = IN_PKT;
            end
          end else begin
            nosop_d = 1'b1;
          end
        end
        IN_PKT: begin
          if (snk_startofpacket_i) begin
            c0_vld = 1'b1;
            c0_len = len_q;
            c0_err = err_q | err_bit(ERR_DUP_SOP);
            len_d  = LEN_ONE;
            prev_d = snk_data_i;
            err_d  = '0;
            if (snk_endofpacket_i) begin
              c1_vld  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            len_d  = step_len;
            err_d  = step_err;
            prev_d = snk_data_i;
            if (snk_endofpacket_i) begin
              c0_vld  = 1'b1;
              c0_len  = step_len;
              c0_err  = step_err;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // One close per cycle leaves the output register. The slot only fills
    // after a DUP_SOP+eop beat, which always lands in IDLE, so at most one
    // new close can arrive while it is occupied.
    if (slot_vld_q) begin
      done_d     = 1'b1;
      out_len_d  = slot_len_q;
      out_err_d  = slot_err_q;
      slot_vld_d = c0_vld;
      slot_len_d = c0_len;
      slot_err_d = c0_err;
    end else begin
      if (c0_vld) begin
        done_d    = 1'b1;
        out_len_d = c0_len;
        out_err_d = c0_err;
      end
      slot_vld_d = c1_vld;
      slot_len_d = LEN_ONE;
      slot_err_d = '0;
    end

    if (clr_i) begin
      state_d    = IDLE;
      len_d      = '0;
      prev_d     = '0;
      err_d      = '0;
      nosop_d    = 1'b0;
      slot_vld_d = 1'b0;
      slot_len_d = '0;
      slot_err_d = '0;
      done_d     = 1'b0;
      out_len_d  = '0;
      out_err_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      prev_q     <= '0;
      err_q      <= '0;
      nosop_q    <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_len_q <= '0;
      slot_err_q <= '0;
      done_q     <= 1'b0;
      out_len_q  <= '0;
      out_err_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      nosop_q    <= nosop_d;
      slot_vld_q <= slot_vld_d;
      slot_len_q <= slot_len_d;
      slot_err_q <= slot_err_d;
      done_q     <= done_d;
      out_len_q  <= out_len_d;
      out_err_q  <= out_err_d;
      ready_q    <= ready_d;
    end
  end

  sorting_sat_cnt #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .clr_i   (clr_i),
    .inc_i   (done_d),
    .cnt_o   (pkt_cnt_o)
  );

  sorting_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .clr_i   (clr_i),
    .inc_i   (done_d & (|out_err_d)),
    .cnt_o   (err_cnt_o)
  );

  assign snk_ready_o = ready_q;
  assign pkt_done_o  = done_q;
  assign pkt_len_o   = out_len_q;
  assign pkt_err_o   = out_err_q;

endmodule
